hbram_cmd_arb: RTL and testbench
================================

Name: hbram_cmd_arb

Overview:
- Multi-channel successor to the single-requester HyperRAM command controller.
- Accepts read/write requests from CH_NUM independent register-interface channels (SPI slaves, DMA stubs) and queues one pending request per channel.
- Arbitrates pending requests round-robin and issues each one to the HyperRAM controller through the ram_en/ram_addr/ram_rdwr handshake.
- Adds a per-request done pulse and a watchdog timeout that the single-channel version lacks.

Parameters:
CH_NUM, 2, number of request channels (1..8)
CTRL_WIDTH, 8, width of each channel's control code
ADDR_WIDTH, 8, width of each channel's address (<= 31)
CTRL_WRITE, 8'h01, control code for a write request
CTRL_READ, 8'h00, control code for a read request
TIMEOUT, 1024, max cycles allowed from ISSUE entry to transaction completion
CH_W, $clog2(CH_NUM) min 1, derived width of channel index

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hbc_cal_pass  in  1  PSRAM calibration complete
req_valid  in  CH_NUM  per-channel one-cycle request strobe
req_ctrl  in  CH_NUM*CTRL_WIDTH  packed control codes, channel i at [i*CTRL_WIDTH +: CTRL_WIDTH]
req_addr  in  CH_NUM*ADDR_WIDTH  packed addresses, same packing
req_pend  out  CH_NUM  channel has an accepted, unfinished request
req_done  out  CH_NUM  one-cycle pulse when that channel's transaction completes
ram_idle  in  1  1 = HyperRAM controller idle, 0 = operating
ram_en  out  1  operation start request
ram_addr  out  32  start address: {1'b1, zero-extended address}
ram_rdwr  out  1  0 = write, 1 = read
ram_ch  out  CH_W  channel currently granted
tout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values:
  - req_pend = 0, req_done = 0, ram_en = 0, ram_addr = 32'h8000_0000, ram_rdwr = 0, ram_ch = 0, tout_err = 0.
  - State = CAL, last grant = CH_NUM-1, ram_idle_d1 = 1.
  - Reset mid-transaction abandons it immediately; all pending requests are lost.
- Edge detection: ram_idle_d1 is registered; fall = ram_idle_d1 & ~ram_idle; rise = ~ram_idle_d1 & ram_idle.
- Request capture, per channel:
  - req_valid[i] with req_pend[i]=0 and ctrl equal to CTRL_WRITE or CTRL_READ: latch ctrl/addr; req_pend[i]=1 next cycle.
  - Any other ctrl code: ignored.
  - req_valid[i] while req_pend[i]=1: ignored; latched copy is not overwritten.
  - Capture runs in every state, including CAL.
- State machine:
  - CAL: wait for hbc_cal_pass=1, then go to READY.
  - READY: if any req_pend, grant the first pending channel searching from last_grant+1 upward with wrap. In the same edge, load ram_ch, ram_addr, ram_rdwr (1 iff latched ctrl = CTRL_READ), update last_grant, go to ISSUE. If nothing is pending, stay.
  - ISSUE: ram_en <= ram_idle (registered, one cycle behind). On fall, go to WAIT and drop ram_en.
  - WAIT: ram_en = 0. On rise, pulse req_done[ram_ch], clear req_pend[ram_ch], go to READY.
  - ERR: one cycle. Pulse tout_err, clear req_pend[ram_ch] (request discarded, no req_done), go to READY.
- Watchdog: counter clears on READY->ISSUE and increments in ISSUE/WAIT. Reaching TIMEOUT-1 forces the next state to ERR, with priority over fall/rise in that cycle.
- hbc_cal_pass dropping in any non-CAL state: next state CAL, ram_en=0. The granted request stays pending and is re-arbitrated later; no done or err pulse.
- ram_rdwr returns to 0 and ram_addr holds its value outside ISSUE/WAIT.
- Simultaneous events:
  - req_valid[i] in the same cycle as clearing req_pend[i]: clear wins; the new request is dropped. The requester must wait for req_pend low.
  - A request arriving while READY is granting another channel is captured and waits its turn.
- Fairness: with all channels continuously pending, grants rotate 0,1,...,CH_NUM-1,0.

Decomposition:
- Shared package hbram_pkg holds:
  - state encodings CAL/READY/ISSUE/WAIT/ERR (3 bits)
  - default CTRL_WRITE/CTRL_READ codes
  - RAM_ADDR_FLAG = 32'h8000_0000
- One sub-module, rr_arbiter: inputs pending vector and last_grant, outputs grant index and grant_valid. Combinational, parametrised on CH_NUM.

Test Plan:
- Cal gating: req_valid[0] with ctrl=8'h01, addr=8'h12, hbc_cal_pass=0 -> req_pend[0]=1, ram_en stays 0. Raise cal -> ram_addr=32'h8000_0012, ram_rdwr=0, ram_ch=0, ram_en high while ram_idle=1.
- Full read handshake: ch1 ctrl=8'h00, addr=8'h34. Model drops ram_idle 3 cycles after ram_en, raises it 10 cycles later -> ram_rdwr=1, ram_en low after fall, req_done[1] one-cycle pulse after rise, req_pend[1]=0.
- Round-robin: both channels requested in the same cycle after reset -> grant order ch0 then ch1. Re-request ch0 during ch1's transaction -> ch0 served next.
- Invalid/duplicate: ctrl=8'h05 -> no req_pend. Second req_valid on a pending channel with addr=8'hFF -> issued address keeps the first value.
- Watchdog: TIMEOUT=16, ram_idle held 1 forever -> tout_err pulses at cycle 16 after ISSUE entry, req_pend cleared, no req_done, state READY.
- Cal loss and reset: drop hbc_cal_pass in WAIT -> ram_en=0, req_pend held, reissued after cal returns. Assert reset_n low mid-ISSUE -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/hbram_pkg.sv
// Shared types and constants for the multi-channel HyperRAM command arbiter.
package hbram_pkg;

    typedef enum logic [2:0] {
        StCal   = 3'd0,
        StReady = 3'd1,
        StIssue = 3'd2,
        StWait  = 3'd3,
        StErr   = 3'd4
    } hb_state_e;

    localparam logic [7:0]  DEF_CTRL_WRITE = 8'h01;
    localparam logic [7:0]  DEF_CTRL_READ  = 8'h00;
    localparam logic [31:0] RAM_ADDR_FLAG  = 32'h8000_0000;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hbram_cmd_arb_rr_arbiter.sv
// Combinational round-robin pick: first pending channel after last_grant, with wrap.
module rr_arbiter import hbram_pkg::*; #(
    parameter int unsigned CH_NUM = 2,
    localparam int unsigned CH_W = idx_width(CH_NUM)
) (
    input  logic [CH_NUM-1:0] pending,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   grant,
    output logic              grant_valid
);

    logic            hi_hit;
    logic            lo_hit;
    logic [CH_W-1:0] hi_idx;
    logic [CH_W-1:0] lo_idx;

    // Lowest pending index above last_grant wins; otherwise lowest pending index overall.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (CH_W'(i) > last_grant) begin
                    hi_hit = 1'b1;
                    hi_idx = CH_W'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = CH_W'(i);
                end
            end
        end
        grant_valid = hi_hit | lo_hit;
        grant       = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/hbram_cmd_arb.sv
// Multi-channel HyperRAM command arbiter: one pending request per channel, round-robin
// issue through the ram_en/ram_idle handshake, per-request done pulse and watchdog.
module hbram_cmd_arb import hbram_pkg::*; #(
    parameter int unsigned            CH_NUM     = 2,
    parameter int unsigned            CTRL_WIDTH = 8,
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter logic [CTRL_WIDTH-1:0]  CTRL_WRITE = CTRL_WIDTH'(DEF_CTRL_WRITE),
    parameter logic [CTRL_WIDTH-1:0]  CTRL_READ  = CTRL_WIDTH'(DEF_CTRL_READ),
    parameter int unsigned            TIMEOUT    = 1024,
    localparam int unsigned           CH_W       = idx_width(CH_NUM)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         hbc_cal_pass,
    input  logic [CH_NUM-1:0]            req_valid,
    input  logic [CH_NUM*CTRL_WIDTH-1:0] req_ctrl,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] req_addr,
    output logic [CH_NUM-1:0]            req_pend,
    output logic [CH_NUM-1:0]            req_done,
    input  logic                         ram_idle,
    output logic                         ram_en,
    output logic [31:0]                  ram_addr,
    output logic                         ram_rdwr,
    output logic [CH_W-1:0]              ram_ch,
    output logic                         tout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    hb_state_e state_q, state_d;

    logic [CH_NUM-1:0]     pend_q, pend_d;
    logic [CH_NUM-1:0]     accept;
    logic [CH_NUM-1:0]     clr;
    logic [CH_NUM-1:0]     done_q;
    logic [CTRL_WIDTH-1:0] ctrl_q [CH_NUM];
    logic [ADDR_WIDTH-1:0] addr_q [CH_NUM];

    logic                  ram_idle_d1;
    logic                  fall, rise;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_rdwr_q, ram_rdwr_d;
    logic [31:0]           ram_addr_q, ram_addr_d;
    logic [CH_W-1:0]       ram_ch_q, ram_ch_d;
    logic [CH_W-1:0]       last_grant_q, last_grant_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  wd_expire;
    logic                  done_go, err_go;

    logic [CH_W-1:0]       grant;
    logic                  grant_valid;
    logic [CTRL_WIDTH-1:0] sel_ctrl;
    logic [ADDR_WIDTH-1:0] sel_addr;

    rr_arbiter #(
        .CH_NUM (CH_NUM)
    ) u_rr_arbiter (
        .pending     (pend_q),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign fall      = ram_idle_d1 & ~ram_idle;
    assign rise      = ~ram_idle_d1 & ram_idle;
    assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

    // Pick the latched request of the granted channel.
    always_comb begin
        sel_ctrl = '0;
        sel_addr = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (grant == CH_W'(i)) begin
                sel_ctrl = ctrl_q[i];
                sel_addr = addr_q[i];
            end
        end
    end

    // Per-channel capture and clear; a clear can never coincide with a capture since
    // captures need the channel idle and clears need it pending.
    always_comb begin
        accept = '0;
        clr    = '0;
        pend_d = pend_q;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            accept[i] = req_valid[i] & ~pend_q[i] &
                        ((req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH] == CTRL_WRITE) |
                         (req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH] == CTRL_READ));
            clr[i]    = (done_go | err_go) & (ram_ch_q == CH_W'(i));
            pend_d[i] = ~clr[i] & (pend_q[i] | accept[i]);
        end
    end

    // Next-state and registered-output logic; calibration loss overrides everything.
    always_comb begin
        state_d      = state_q;
        ram_en_d     = 1'b0;
        ram_rdwr_d   = ram_rdwr_q;
        ram_addr_d   = ram_addr_q;
        ram_ch_d     = ram_ch_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        done_go      = 1'b0;
        err_go       = 1'b0;
        if ((state_q != StCal) && !hbc_cal_pass) begin
            // Granted request stays pending and is re-arbitrated once calibrated again.
            state_d    = StCal;
            ram_rdwr_d = 1'b0;
            err_go     = (state_q == StErr);
        end else begin
            unique case (state_q)
                StCal: begin
                    if (hbc_cal_pass) state_d = StReady;
                end
                StReady: begin
                    if (grant_valid) begin
                        state_d      = StIssue;
                        ram_ch_d     = grant;
                        ram_addr_d   = RAM_ADDR_FLAG | 32'(sel_addr);
                        ram_rdwr_d   = (sel_ctrl == CTRL_READ);
                        last_grant_d = grant;
                        wd_d         = '0;
                    end
                end
                StIssue: begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_expire) begin
                        state_d    = StErr;
                        ram_rdwr_d = 1'b0;
                    end else if (fall) begin
                        state_d = StWait;
                    end else begin
                        ram_en_d = ram_idle;
                    end
                end
                StWait: begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_expire) begin
                        state_d    = StErr;
                        ram_rdwr_d = 1'b0;
                    end else if (rise) begin
                        state_d    = StReady;
                        done_go    = 1'b1;
                        ram_rdwr_d = 1'b0;
                    end
                end
                StErr: begin
                    err_go  = 1'b1;
                    state_d = StReady;
                end
                default: state_d = StCal;
            endcase
        end
    end

    // Control state and handshake registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StCal;
            ram_idle_d1  <= 1'b1;
            ram_en_q     <= 1'b0;
            ram_rdwr_q   <= 1'b0;
            ram_addr_q   <= RAM_ADDR_FLAG;
            ram_ch_q     <= '0;
            last_grant_q <= CH_W'(CH_NUM - 1);
            wd_q         <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            ram_idle_d1  <= ram_idle;
            ram_en_q     <= ram_en_d;
            ram_rdwr_q   <= ram_rdwr_d;
            ram_addr_q   <= ram_addr_d;
            ram_ch_q     <= ram_ch_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            done_q       <= clr & {CH_NUM{done_go}};
        end
    end

    // Per-channel request store.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            for (int i = 0; i < int'(CH_NUM); i++) begin
                ctrl_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < int'(CH_NUM); i++) begin
                if (accept[i]) begin
                    ctrl_q[i] <= req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
                    addr_q[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    assign req_pend = pend_q;
    assign req_done = done_q;
    assign ram_en   = ram_en_q;
    assign ram_addr = ram_addr_q;
    assign ram_rdwr = ram_rdwr_q;
    assign ram_ch   = ram_ch_q;
    assign tout_err = (state_q == StErr);

endmodule

// File: tb/tb_hbram_cmd_arb.sv
// Bench for hbram_cmd_arb: directed scenarios, literal spot checks and a per-cycle
// behavioural model compared on every falling clock edge.
module tb_hbram_cmd_arb;

    localparam int N  = 2;
    localparam int TO = 16;

    logic           clock        = 1'b0;
    logic           reset_n      = 1'b0;
    logic           hbc_cal_pass = 1'b0;
    logic           ram_idle     = 1'b1;
    logic [N-1:0]   req_valid    = '0;
    logic [N*8-1:0] req_ctrl     = '0;
    logic [N*8-1:0] req_addr     = '0;
    logic [N-1:0]   req_pend;
    logic [N-1:0]   req_done;
    logic           ram_en;
    logic [31:0]    ram_addr;
    logic           ram_rdwr;
    logic [0:0]     ram_ch;
    logic           tout_err;

    int errors = 0;
    int checks = 0;

    hbram_cmd_arb #(
        .CH_NUM     (N),
        .CTRL_WIDTH (8),
        .ADDR_WIDTH (8),
        .CTRL_WRITE (8'h01),
        .CTRL_READ  (8'h00),
        .TIMEOUT    (TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .hbc_cal_pass (hbc_cal_pass),
        .req_valid    (req_valid),
        .req_ctrl     (req_ctrl),
        .req_addr     (req_addr),
        .req_pend     (req_pend),
        .req_done     (req_done),
        .ram_idle     (ram_idle),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ram_rdwr     (ram_rdwr),
        .ram_ch       (ram_ch),
        .tout_err     (tout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks requests per channel and the life of the one outstanding RAM transaction.
    bit [N-1:0]  m_pend;
    logic [7:0]  m_ctrl [N];
    logic [7:0]  m_addr [N];
    bit          m_online;   // calibrated and arbitrating
    bit          m_active;   // a grant is out on the RAM interface
    bit          m_waiting;  // RAM has accepted (went busy)
    bit          m_err;      // timeout cycle
    bit          m_idle_d1;
    int          m_age, m_cur, m_last;
    bit          e_en, e_rdwr;
    bit [31:0]   e_addr;
    int          e_ch;
    bit [N-1:0]  e_done;

    task automatic model_reset();
        m_pend = '0; m_online = 0; m_active = 0; m_waiting = 0; m_err = 0;
        m_idle_d1 = 1; m_age = 0; m_cur = 0; m_last = N - 1;
        e_en = 0; e_rdwr = 0; e_addr = 32'h8000_0000; e_ch = 0; e_done = '0;
        for (int i = 0; i < N; i++) begin
            m_ctrl[i] = 8'h00;
            m_addr[i] = 8'h00;
        end
    endtask

    task automatic model_step();
        bit fall, rise;
        bit [N-1:0] acc;
        int c;
        fall = m_idle_d1 && !ram_idle;
        rise = !m_idle_d1 && ram_idle;
        m_idle_d1 = ram_idle;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            logic [7:0] cc;
            cc = req_ctrl[i*8 +: 8];
            if (req_valid[i] && !m_pend[i] && (cc == 8'h01 || cc == 8'h00)) acc[i] = 1;
        end
        e_en = 0;
        e_done = '0;
        if (m_err) m_pend[m_cur] = 0;
        if (m_online && !hbc_cal_pass) begin
            m_online = 0; m_active = 0; m_err = 0; e_rdwr = 0;
        end else if (!m_online) begin
            m_online = hbc_cal_pass;
        end else if (m_err) begin
            m_err = 0;
        end else if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!m_active && m_pend[c]) begin
                    m_active = 1; m_waiting = 0; m_age = 0; m_cur = c; m_last = c;
                    e_ch = c;
                    e_addr = 32'h8000_0000 | {24'd0, m_addr[c]};
                    e_rdwr = (m_ctrl[c] == 8'h00);
                end
            end
        end else begin
            if (m_age == TO - 1) begin
                m_active = 0; m_err = 1; e_rdwr = 0;
            end else if (!m_waiting) begin
                if (fall) m_waiting = 1;
                else e_en = ram_idle;
            end else if (rise) begin
                m_active = 0; e_done[m_cur] = 1; m_pend[m_cur] = 0; e_rdwr = 0;
            end
            m_age++;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                m_pend[i] = 1;
                m_ctrl[i] = req_ctrl[i*8 +: 8];
                m_addr[i] = req_addr[i*8 +: 8];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check("cyc_pend",  32'(req_pend), 32'(m_pend));
                check("cyc_done",  32'(req_done), 32'(e_done));
                check("cyc_en",    32'(ram_en),   32'(e_en));
                check("cyc_addr",  ram_addr,      e_addr);
                check("cyc_rdwr",  32'(ram_rdwr), 32'(e_rdwr));
                check("cyc_ch",    32'(ram_ch),   32'(e_ch));
                check("cyc_tout",  32'(tout_err), 32'(m_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic request(input int ch, input logic [7:0] c, input logic [7:0] a);
        req_valid[ch]       = 1'b1;
        req_ctrl[ch*8 +: 8] = c;
        req_addr[ch*8 +: 8] = a;
        step();
        req_valid = '0;
    endtask

    task automatic wait_en(input string name);
        int n;
        n = 0;
        while (ram_en !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(name, 32'(ram_en), 32'd1);
    endtask

    // RAM side: go busy 'pre' cycles after ram_en is seen, stay busy 'busy' cycles.
    task automatic ram_txn(input int pre, input int busy);
        repeat (pre) step();
        ram_idle = 1'b0;
        step();
        check("en_drop", 32'(ram_en), 32'd0);
        repeat (busy - 1) step();
        ram_idle = 1'b1;
        step();
    endtask

    initial begin
        int n;
        // Reset values
        step();
        step();
        check("rst_pend", 32'(req_pend), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        check("rst_en",   32'(ram_en),   32'd0);
        check("rst_addr", ram_addr,      32'h8000_0000);
        check("rst_rdwr", 32'(ram_rdwr), 32'd0);
        check("rst_ch",   32'(ram_ch),   32'd0);
        check("rst_tout", 32'(tout_err), 32'd0);
        reset_n = 1'b1;
        step();

        // Capture while uncalibrated, issue once calibration passes
        request(0, 8'h01, 8'h12);
        check("cal_pend", 32'(req_pend), 32'd1);
        repeat (3) step();
        check("cal_en_low", 32'(ram_en), 32'd0);
        hbc_cal_pass = 1'b1;
        wait_en("cal_en");
        check("cal_addr", ram_addr,      32'h8000_0012);
        check("cal_rdwr", 32'(ram_rdwr), 32'd0);
        check("cal_ch",   32'(ram_ch),   32'd0);
        ram_txn(3, 10);
        check("w0_done", 32'(req_done), 32'd1);
        check("w0_pend", 32'(req_pend), 32'd0);
        step();
        check("w0_done_pulse", 32'(req_done), 32'd0);

        // Read handshake on channel 1
        request(1, 8'h00, 8'h34);
        wait_en("rd_en");
        check("rd_rdwr", 32'(ram_rdwr), 32'd1);
        check("rd_addr", ram_addr,      32'h8000_0034);
        check("rd_ch",   32'(ram_ch),   32'd1);
        ram_txn(3, 10);
        check("rd_done",  32'(req_done), 32'd2);
        check("rd_pend",  32'(req_pend), 32'd0);
        check("rd_rdwr0", 32'(ram_rdwr), 32'd0);

        // Asynchronous reset in the middle of ISSUE
        request(0, 8'h01, 8'h56);
        wait_en("mid_en");
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_en",   32'(ram_en),   32'd0);
        check("arst_addr", ram_addr,      32'h8000_0000);
        check("arst_pend", 32'(req_pend), 32'd0);
        check("arst_ch",   32'(ram_ch),   32'd0);
        check("arst_rdwr", 32'(ram_rdwr), 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // Round robin: both channels at once, then ch0 re-requested during ch1
        req_valid = 2'b11;
        req_ctrl  = {8'h00, 8'h01};
        req_addr  = {8'h21, 8'h20};
        step();
        req_valid = '0;
        wait_en("rr_en0");
        check("rr_ch0",   32'(ram_ch), 32'd0);
        check("rr_addr0", ram_addr,    32'h8000_0020);
        ram_txn(3, 10);
        check("rr_done0", 32'(req_done), 32'd1);
        wait_en("rr_en1");
        check("rr_ch1",   32'(ram_ch),   32'd1);
        check("rr_addr1", ram_addr,      32'h8000_0021);
        check("rr_rdwr1", 32'(ram_rdwr), 32'd1);
        request(0, 8'h01, 8'h22);
        request(0, 8'h01, 8'hFF);
        check("rr_both_pend", 32'(req_pend), 32'd3);
        ram_txn(1, 10);
        check("rr_done1", 32'(req_done), 32'd2);
        wait_en("rr_en2");
        check("rr_ch2",   32'(ram_ch), 32'd0);
        check("dup_addr", ram_addr,    32'h8000_0022);
        ram_txn(3, 10);
        check("rr_done2", 32'(req_done), 32'd1);

        // Unknown control code is ignored
        request(1, 8'h05, 8'h44);
        check("inv_pend", 32'(req_pend), 32'd0);
        step();
        check("inv_en", 32'(ram_en), 32'd0);

        // Watchdog: RAM never goes busy
        request(0, 8'h01, 8'h70);
        wait_en("wd_en");
        n = 0;
        while (tout_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("wd_latency", 32'(n), 32'd15);
        check("wd_nodone",  32'(req_done), 32'd0);
        check("wd_en_low",  32'(ram_en),   32'd0);
        step();
        check("wd_pulse", 32'(tout_err), 32'd0);
        check("wd_pend",  32'(req_pend), 32'd0);

        // Calibration loss while waiting on the RAM
        request(1, 8'h00, 8'h55);
        wait_en("cl_en");
        repeat (3) step();
        ram_idle = 1'b0;
        step();
        check("cl_wait_en", 32'(ram_en), 32'd0);
        hbc_cal_pass = 1'b0;
        step();
        check("cl_en",   32'(ram_en),   32'd0);
        check("cl_pend", 32'(req_pend), 32'd2);
        step();
        check("cl_tout", 32'(tout_err), 32'd0);
        check("cl_done", 32'(req_done), 32'd0);
        ram_idle = 1'b1;
        step();
        hbc_cal_pass = 1'b1;
        wait_en("cl_reissue");
        check("cl_ch",   32'(ram_ch),   32'd1);
        check("cl_addr", ram_addr,      32'h8000_0055);
        check("cl_rdwr", 32'(ram_rdwr), 32'd1);
        ram_txn(3, 10);
        check("cl_done2", 32'(req_done), 32'd2);
        check("cl_pend2", 32'(req_pend), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
